// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and a word-wide, big-endian data memory.
// Optional range check against MEM_BYTES is enabled by defining LSU_RANGE_CHECK_EN.
module lsu_mem_ctrl #(
  parameter int unsigned WORD      = 32,
  parameter int unsigned MEM_BYTES = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [WORD-1:0] resp_rdata,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [WORD-1:0] mem_rdata
);

`ifdef LSU_RANGE_CHECK_EN
  localparam bit RangeCheck = 1'b1;
`else
  localparam bit RangeCheck = 1'b0;
`endif

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [1:0]      off_q, off_d;
  logic [WORD-1:0] wdata_q, wdata_d;

  logic            req_ready_q, resp_valid_q, resp_err_q, mem_read_q, mem_write_q;
  logic            resp_err_d;
  logic [WORD-1:0] resp_rdata_q, resp_rdata_d;
  logic [WORD-1:0] mem_addr_q, mem_addr_d;
  logic [WORD-1:0] mem_wdata_q, mem_wdata_d;

  logic            req_err, over_range;
  logic [WORD:0]   acc_bytes, req_end;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [WORD-1:0] load_val, merged;

  // Alignment first, then the optional end-of-memory check.
  always_comb begin
    unique case (req_op[1:0])
      SzByte:  acc_bytes = (WORD+1)'(1);
      SzHalf:  acc_bytes = (WORD+1)'(2);
      default: acc_bytes = (WORD+1)'(4);
    endcase
    req_end    = {1'b0, req_addr} + acc_bytes;
    over_range = req_end > (WORD+1)'(MEM_BYTES);
    unique case (req_op[1:0])
      SzByte:  req_err = 1'b0;
      SzHalf:  req_err = req_addr[0];
      SzWord:  req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (RangeCheck && over_range) req_err = 1'b1;
  end

  // Big-endian lanes: byte offset 0 is the most significant byte.
  always_comb begin
    unique case (off_q)
      2'd0:    rd_byte = mem_rdata[31:24];
      2'd1:    rd_byte = mem_rdata[23:16];
      2'd2:    rd_byte = mem_rdata[15:8];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half  = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    load_val = mem_rdata;
    merged   = mem_rdata;
    if (op_q[1:0] == SzByte) begin
      load_val = op_q[2] ? {{(WORD-8){1'b0}}, rd_byte} : {{(WORD-8){rd_byte[7]}}, rd_byte};
      unique case (off_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (op_q[1:0] == SzHalf) begin
      load_val = op_q[2] ? {{(WORD-16){1'b0}}, rd_half} : {{(WORD-16){rd_half[15]}}, rd_half};
      if (off_q[1]) merged[15:0] = wdata_q[15:0];
      else          merged[31:16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d       = req_op;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata;
          mem_addr_d = {req_addr[WORD-1:2], 2'b00};
          if (req_err) begin
            state_d    = StDone;
            resp_err_d = 1'b1;
          end else if (req_op[3] && req_op[1:0] == SzWord) begin
            state_d     = StWr;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (op_q[3]) begin
          state_d     = StWr;
          mem_wdata_d = merged;
        end else begin
          state_d      = StDone;
          resp_rdata_d = load_val;
        end
      end
      StWr:    state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Strobes and handshakes are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= (state_d == StIdle);
      resp_valid_q <= (state_d == StDone);
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= (state_d == StRd);
      mem_write_q  <= (state_d == StWr);
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed plan cases plus randomized traffic
// checked against a byte-array big-endian memory model.
module tb_lsu_mem_ctrl;

`ifdef LSU_RANGE_CHECK_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif
  localparam longint MemBytes = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.WORD(32), .MEM_BYTES(1000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  // Data memory: combinational read, write on negedge.
  logic [31:0] tb_mem [256] = '{default: '0};
  assign mem_rdata = tb_mem[mem_addr[9:2]];
  always @(negedge clk) if (mem_write) tb_mem[mem_addr[9:2]] <= mem_wdata;

  int checks = 0;
  int errors = 0;

  // Reference model: plain byte array, address 0 holds the most significant byte of word 0.
  logic [7:0] ref_mem [1024];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic ref_err(input logic [3:0] op, input logic [31:0] addr);
    if (op[1:0] == 2'b11) return 1'b1;
    if ((addr % 32'(nbytes(op[1:0]))) != 0) return 1'b1;
    if (RangeEn && (longint'(addr) + nbytes(op[1:0]) > MemBytes)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr);
    int n = nbytes(op[1:0]);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[23:0], ref_mem[int'(addr[9:0]) + i]};
    if (!op[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic void ref_store(input logic [3:0] op, input logic [31:0] addr,
                                    input logic [31:0] wdata);
    int n = nbytes(op[1:0]);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = wdata >> (8*(n-1-i));
      ref_mem[int'(addr[9:0]) + i] = t[7:0];
    end
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int a = int'(addr[9:0]) & ~3;
    return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
  endfunction

  // Observations of the most recent transaction.
  int          r_lat, r_nrd, r_nwr;
  logic [31:0] r_rdata, r_wdata, r_waddr, r_raddr;
  logic        r_err, r_rdy, r_both;

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    int w = 0;
    r_lat = -1; r_nrd = 0; r_nwr = 0; r_both = 1'b0; r_rdy = 1'bx;
    r_rdata = 'x; r_err = 1'bx; r_wdata = 'x; r_waddr = 'x; r_raddr = 'x;
    @(negedge clk);
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    // Scramble the request bus so any failure to latch shows up.
    req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read) begin r_nrd++; r_raddr = mem_addr; end
      if (mem_write) begin r_nwr++; r_wdata = mem_wdata; r_waddr = mem_addr; end
      if (mem_read && mem_write) r_both = 1'b1;
      if (resp_valid) begin
        r_lat = c; r_rdata = resp_rdata; r_err = resp_err; r_rdy = req_ready;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b want 10000",
               {req_ready, resp_valid, resp_err, mem_read, mem_write});
    end
    checks++;
    if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++;
    if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, mem_read, mem_write} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 1000", {req_ready, resp_valid, mem_read, mem_write});
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, wdata, rdata;
    int          lat, nrd, nwr;
    logic [31:0] mw;
  } dir_t;

  task automatic test_directed();
    dir_t tbl [9];
    tbl[0] = '{4'b1010, 32'd8,  32'h11223344, 32'h00000000, 2, 0, 1, 32'h11223344};
    tbl[1] = '{4'b0010, 32'd8,  32'h0,        32'h11223344, 2, 1, 0, 32'h0};
    tbl[2] = '{4'b0000, 32'd9,  32'h0,        32'h00000022, 2, 1, 0, 32'h0};
    tbl[3] = '{4'b0100, 32'd9,  32'h0,        32'h00000022, 2, 1, 0, 32'h0};
    tbl[4] = '{4'b0001, 32'd10, 32'h0,        32'h00003344, 2, 1, 0, 32'h0};
    tbl[5] = '{4'b1000, 32'd10, 32'h000000F0, 32'h00000000, 3, 1, 1, 32'h1122F044};
    tbl[6] = '{4'b0000, 32'd10, 32'h0,        32'hFFFFFFF0, 2, 1, 0, 32'h0};
    tbl[7] = '{4'b0100, 32'd10, 32'h0,        32'h000000F0, 2, 1, 0, 32'h0};
    tbl[8] = '{4'b0010, 32'd8,  32'h0,        32'h1122F044, 2, 1, 0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      do_req(tbl[i].op, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].op[3]) ref_store(tbl[i].op, tbl[i].addr, tbl[i].wdata);
      checks++;
      if (r_lat !== tbl[i].lat || r_err !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_lat_err got lat=%0d err=%b want lat=%0d err=0", i, r_lat, r_err,
                 tbl[i].lat);
      end
      checks++;
      if (r_rdata !== tbl[i].rdata) begin
        errors++;
        $display("FAIL dir%0d_rdata got %h want %h", i, r_rdata, tbl[i].rdata);
      end
      checks++;
      if (r_nrd !== tbl[i].nrd || r_nwr !== tbl[i].nwr) begin
        errors++;
        $display("FAIL dir%0d_strobes got rd=%0d wr=%0d want rd=%0d wr=%0d", i, r_nrd, r_nwr,
                 tbl[i].nrd, tbl[i].nwr);
      end
      if (tbl[i].nwr == 1) begin
        checks++;
        if (r_wdata !== tbl[i].mw || r_waddr !== 32'd8) begin
          errors++;
          $display("FAIL dir%0d_write got %h@%h want %h@00000008", i, r_wdata, r_waddr, tbl[i].mw);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [3:0]  ops   [8];
    logic [31:0] addrs [8];
    ops[0] = 4'b1001; addrs[0] = 32'd9;
    ops[1] = 4'b0010; addrs[1] = 32'd6;
    ops[2] = 4'b0011; addrs[2] = 32'd0;
    ops[3] = 4'b1011; addrs[3] = 32'd4;
    ops[4] = 4'b0101; addrs[4] = 32'd3;
    for (int i = 5; i < 8; i++) begin
      ops[i]   = {1'($urandom), 1'($urandom), 2'($urandom_range(1, 2))};
      addrs[i] = {22'($urandom_range(0, 200)), 8'h0} | 32'($urandom_range(0, 1) ? 1 : 3);
    end
    for (int i = 0; i < 8; i++) begin
      do_req(ops[i], addrs[i], $urandom);
      checks++;
      if (r_err !== 1'b1 || r_rdata !== 32'h0 || r_lat !== 1) begin
        errors++;
        $display("FAIL err%0d_resp got err=%b rdata=%h lat=%0d want err=1 rdata=0 lat=1", i, r_err,
                 r_rdata, r_lat);
      end
      checks++;
      if (r_nrd !== 0 || r_nwr !== 0) begin
        errors++;
        $display("FAIL err%0d_strobes got rd=%0d wr=%0d want 0 0", i, r_nrd, r_nwr);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nwr = 0;
    int nresp = 0;
    logic [31:0] exp;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b1001; req_addr = 32'd8; req_wdata = 32'h0000ABCD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL rmw_rd_cycle got mem_read=%b want 1", mem_read); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (mem_write) nwr++;
    checks++;
    if (req_ready !== 1'b1 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got ready=%b rd=%b want 1 0", req_ready, mem_read);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_write) nwr++;
      if (resp_valid) nresp++;
    end
    checks++;
    if (nwr != 0 || nresp != 0) begin
      errors++;
      $display("FAIL abort_quiet got writes=%0d resps=%0d want 0 0", nwr, nresp);
    end
    exp = ref_load(4'b0010, 32'd8);
    do_req(4'b0010, 32'd8, 32'h0);
    checks++;
    if (r_rdata !== exp || r_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_mem_kept got %h err=%b want %h err=0", r_rdata, r_err, exp);
    end
  endtask

  task automatic test_range();
`ifdef LSU_RANGE_CHECK_EN
    logic [3:0]  ops   [4];
    logic [31:0] addrs [4];
    logic        exp_e [4];
    ops[0] = 4'b0010; addrs[0] = 32'd996;  exp_e[0] = 1'b0;
    ops[1] = 4'b0010; addrs[1] = 32'd1000; exp_e[1] = 1'b1;
    ops[2] = 4'b1001; addrs[2] = 32'd998;  exp_e[2] = 1'b0;
    ops[3] = 4'b1001; addrs[3] = 32'd1000; exp_e[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_req(ops[i], addrs[i], 32'h0000BEEF);
      if (ops[i][3] && !exp_e[i]) ref_store(ops[i], addrs[i], 32'h0000BEEF);
      checks++;
      if (r_err !== exp_e[i] || (exp_e[i] && (r_nrd + r_nwr) != 0)) begin
        errors++;
        $display("FAIL range%0d got err=%b strobes=%0d want err=%b", i, r_err, r_nrd + r_nwr,
                 exp_e[i]);
      end
    end
`else
    do_req(4'b0010, 32'd1000, 32'h0);
    checks++;
    if (r_err !== 1'b0 || r_nrd !== 1 || r_raddr !== 32'd1000) begin
      errors++;
      $display("FAIL norange_lw1000 got err=%b rd=%0d addr=%h want 0 1 000003e8", r_err, r_nrd,
               r_raddr);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] addr, wdata, exp_rdata;
    logic        exp_e;
    int          n, exp_lat, exp_rd, exp_wr;
    for (int i = 0; i < 300; i++) begin
      op    = {1'($urandom), 1'($urandom),
               ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2))};
      n     = nbytes(op[1:0]);
      addr  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
      wdata = $urandom;
      exp_e = ref_err(op, addr);
      exp_rdata = 32'h0;
      if (exp_e) begin
        exp_lat = 1; exp_rd = 0; exp_wr = 0;
      end else if (op[3]) begin
        exp_lat = (n == 4) ? 2 : 3; exp_rd = (n == 4) ? 0 : 1; exp_wr = 1;
      end else begin
        exp_lat = 2; exp_rd = 1; exp_wr = 0; exp_rdata = ref_load(op, addr);
      end
      do_req(op, addr, wdata);
      if (!exp_e && op[3]) ref_store(op, addr, wdata);
      checks++;
      if (r_lat !== exp_lat || r_err !== exp_e || r_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL rnd%0d_resp op=%b addr=%0d got lat=%0d err=%b rdata=%h want %0d %b %h",
                 i, op, addr, r_lat, r_err, r_rdata, exp_lat, exp_e, exp_rdata);
      end
      checks++;
      if (r_nrd !== exp_rd || r_nwr !== exp_wr || r_both !== 1'b0 || r_rdy !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_strobes got rd=%0d wr=%0d both=%b rdy=%b want %0d %0d 0 0",
                 i, r_nrd, r_nwr, r_both, r_rdy, exp_rd, exp_wr);
      end
      if (exp_wr == 1) begin
        checks++;
        if (r_wdata !== ref_word(addr) || r_waddr !== (addr & ~32'd3)) begin
          errors++;
          $display("FAIL rnd%0d_write got %h@%h want %h@%h", i, r_wdata, r_waddr, ref_word(addr),
                   addr & ~32'd3);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
    test_reset();
    test_directed();
    test_errors();
    test_reset_mid();
    test_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
